// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter that locks a UART transmitter to one requester for a whole packet,
// with a stall timeout that forcibly releases a grant whose requester goes quiet.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | no grant held; outputs quiet; picks next requester round-robin
// S_LOCK | grant held; granted requester passed straight through to tx_*
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_valid,
    output logic [DATA_W-1:0]            tx_data,
    input  logic                         tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]   tx_src,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [SRC_W-1:0] LAST_RST    = SRC_W'(NUM_REQ - 1);

    typedef enum logic {S_IDLE, S_LOCK} state_e;

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               timeout_q, timeout_d;

    logic               found;
    logic [SRC_W-1:0]   pick;
    logic [SRC_W-1:0]   idx;
    logic               g_valid;
    logic               g_last;
    logic [DATA_W-1:0]  g_data;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = SRC_W'((int'(last_grant_q) + off) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign g_valid = req_valid[grant_q];
    assign g_last  = req_last[grant_q];
    assign g_data  = req_data[int'(grant_q)*DATA_W +: DATA_W];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        stall_d      = stall_q;
        timeout_d    = 1'b0;
        req_ready    = '0;
        tx_valid     = 1'b0;
        tx_data      = '0;
        busy         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_LOCK;
                    grant_d = pick;
                    stall_d = '0;
                end
            end
            S_LOCK: begin
                busy               = 1'b1;
                tx_valid           = g_valid;
                tx_data            = g_data;
                req_ready[grant_q] = tx_ready;
                // A valid byte always resets the stall count, even when it races the limit.
                if (g_valid) begin
                    stall_d = '0;
                    if (tx_ready && g_last) begin
                        state_d      = S_IDLE;
                        last_grant_d = grant_q;
                    end
                end else if (stall_q == STALL_LIMIT) begin
                    state_d      = S_IDLE;
                    last_grant_d = grant_q;
                    stall_d      = '0;
                    timeout_d    = 1'b1;
                end else begin
                    stall_d = stall_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            stall_q      <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            stall_q      <= stall_d;
            timeout_q    <= timeout_d;
        end
    end

    assign tx_src      = grant_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized packet
// traffic scored against a round-robin packet-order model.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TO = 8;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              tx_valid;
    logic [DW-1:0]     tx_data;
    logic              tx_ready;
    logic [1:0]        tx_src;
    logic              busy;
    logic              timeout_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .IDLE_TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .tx_src(tx_src), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic set_lane(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]        = v;
        req_data[i*DW +: DW] = d;
        req_last[i]         = l;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
    endtask

    // Leaves the bench at a falling edge, reset released, first arbitration on the next rise.
    task automatic do_reset();
        @(negedge clock);
        clear_inputs();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        tx_ready  = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else pass_cnt++;
        chk_cnt++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b exp=0000", req_ready); else pass_cnt++;
        chk_cnt++; if (tx_src !== 2'd0) $display("FAIL reset_tx_src got=%0d exp=0", tx_src); else pass_cnt++;
        chk_cnt++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err got=%0b exp=0", timeout_err); else pass_cnt++;
        chk_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got=%h exp=00", tx_data); else pass_cnt++;
        @(negedge clock);
        clear_inputs();
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] b;
        do_reset();
        tx_ready = 1'b1;
        set_lane(2, 1'b1, 8'h41, 1'b0);
        #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL single_arb_busy got=%0b exp=0", busy); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            b = 8'h41 + 8'(k);
            set_lane(2, 1'b1, b, k == 2);
            #1;
            chk_cnt++;
            if (tx_src !== 2'd2 || tx_valid !== 1'b1 || tx_data !== b || req_ready !== 4'b0100 || busy !== 1'b1)
                $display("FAIL single_byte%0d got src=%0d v=%0b d=%h rdy=%b busy=%0b exp src=2 v=1 d=%h rdy=0100 busy=1",
                         k, tx_src, tx_valid, tx_data, req_ready, busy, b);
            else pass_cnt++;
        end
        @(negedge clock);
        set_lane(2, 1'b1, 8'h44, 1'b1);
        #1;
        chk_cnt++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || req_ready !== 4'b0000 || tx_src !== 2'd2)
            $display("FAIL single_idle_gap got busy=%0b v=%0b rdy=%b src=%0d exp busy=0 v=0 rdy=0000 src=2",
                     busy, tx_valid, req_ready, tx_src);
        else pass_cnt++;
        @(negedge clock);
        #1;
        chk_cnt++;
        if (busy !== 1'b1 || tx_data !== 8'h44)
            $display("FAIL single_regrant got busy=%0b d=%h exp busy=1 d=44", busy, tx_data);
        else pass_cnt++;
        @(negedge clock);
        set_lane(2, 1'b0, 8'h00, 1'b0);
        #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL single_done_busy got=%0b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_contention();
        int order[3] = '{0, 1, 3};
        int n;
        bit got;
        do_reset();
        tx_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) set_lane(order[i], 1'b1, 8'h10 + 8'(order[i]), 1'b1);
            for (int k = 0; k < 3; k++) begin
                n = 0;
                got = 0;
                while (!got && n < 10) begin
                    #1;
                    if (tx_valid && tx_ready) got = 1;
                    else begin
                        @(negedge clock);
                        n++;
                    end
                end
                chk_cnt++;
                if (!got) $display("FAIL contention_wait r%0d k%0d got=no_transfer exp=transfer", r, k);
                else if (tx_src !== 2'(order[k]) || tx_data !== 8'h10 + 8'(order[k]))
                    $display("FAIL contention_order r%0d k%0d got src=%0d d=%h exp src=%0d d=%h",
                             r, k, tx_src, tx_data, order[k], 8'h10 + 8'(order[k]));
                else pass_cnt++;
                @(negedge clock);
                if (got) set_lane(int'(tx_src), 1'b0, 8'h00, 1'b0);
            end
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        tx_ready = 1'b0;
        set_lane(1, 1'b1, 8'h55, 1'b1);
        @(negedge clock);
        for (int i = 0; i < 20; i++) begin
            #1;
            chk_cnt++;
            if (req_ready !== 4'b0000 || timeout_err !== 1'b0 || busy !== 1'b1 || tx_valid !== 1'b1)
                $display("FAIL bp_hold%0d got rdy=%b err=%0b busy=%0b v=%0b exp rdy=0000 err=0 busy=1 v=1",
                         i, req_ready, timeout_err, busy, tx_valid);
            else pass_cnt++;
            @(negedge clock);
        end
        tx_ready = 1'b1;
        #1;
        chk_cnt++;
        if (req_ready !== 4'b0010 || tx_data !== 8'h55 || tx_src !== 2'd1)
            $display("FAIL bp_release got rdy=%b d=%h src=%0d exp rdy=0010 d=55 src=1", req_ready, tx_data, tx_src);
        else pass_cnt++;
        @(negedge clock);
        clear_inputs();
        #1;
        chk_cnt++;
        if (busy !== 1'b0 || timeout_err !== 1'b0)
            $display("FAIL bp_done got busy=%0b err=%0b exp busy=0 err=0", busy, timeout_err);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_reset();
        tx_ready = 1'b1;
        set_lane(0, 1'b1, 8'hA0, 1'b0);
        set_lane(1, 1'b1, 8'hB1, 1'b1);
        @(negedge clock);
        #1;
        chk_cnt++;
        if (tx_src !== 2'd0 || tx_data !== 8'hA0)
            $display("FAIL to_first got src=%0d d=%h exp src=0 d=a0", tx_src, tx_data);
        else pass_cnt++;
        @(negedge clock);
        set_lane(0, 1'b0, 8'h00, 1'b0);
        for (int k = 1; k <= TO; k++) begin
            #1;
            chk_cnt++;
            if (busy !== 1'b1 || timeout_err !== 1'b0)
                $display("FAIL to_stall%0d got busy=%0b err=%0b exp busy=1 err=0", k, busy, timeout_err);
            else pass_cnt++;
            @(negedge clock);
        end
        #1;
        chk_cnt++;
        if (busy !== 1'b0 || timeout_err !== 1'b1 || tx_src !== 2'd0)
            $display("FAIL to_release got busy=%0b err=%0b src=%0d exp busy=0 err=1 src=0", busy, timeout_err, tx_src);
        else pass_cnt++;
        @(negedge clock);
        #1;
        chk_cnt++;
        if (timeout_err !== 1'b0 || busy !== 1'b1 || tx_src !== 2'd1 || tx_data !== 8'hB1)
            $display("FAIL to_next got err=%0b busy=%0b src=%0d d=%h exp err=0 busy=1 src=1 d=b1",
                     timeout_err, busy, tx_src, tx_data);
        else pass_cnt++;
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic test_boundary();
        do_reset();
        tx_ready = 1'b1;
        set_lane(0, 1'b1, 8'hC0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        set_lane(0, 1'b0, 8'h00, 1'b0);
        for (int k = 1; k < TO; k++) @(negedge clock);
        set_lane(0, 1'b1, 8'hC1, 1'b0);
        #1;
        chk_cnt++;
        if (busy !== 1'b1 || tx_data !== 8'hC1 || timeout_err !== 1'b0)
            $display("FAIL bnd_limit got busy=%0b d=%h err=%0b exp busy=1 d=c1 err=0", busy, tx_data, timeout_err);
        else pass_cnt++;
        @(negedge clock);
        set_lane(0, 1'b0, 8'h00, 1'b0);
        for (int k = 1; k <= TO; k++) begin
            #1;
            chk_cnt++;
            if (busy !== 1'b1 || timeout_err !== 1'b0)
                $display("FAIL bnd_restall%0d got busy=%0b err=%0b exp busy=1 err=0", k, busy, timeout_err);
            else pass_cnt++;
            @(negedge clock);
        end
        #1;
        chk_cnt++;
        if (busy !== 1'b0 || timeout_err !== 1'b1)
            $display("FAIL bnd_release got busy=%0b err=%0b exp busy=0 err=1", busy, timeout_err);
        else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        tx_ready = 1'b1;
        set_lane(3, 1'b1, 8'hD0, 1'b0);
        @(negedge clock);
        #1;
        chk_cnt++;
        if (tx_src !== 2'd3 || tx_data !== 8'hD0)
            $display("FAIL rst_mid_grant got src=%0d d=%h exp src=3 d=d0", tx_src, tx_data);
        else pass_cnt++;
        @(negedge clock);
        set_lane(3, 1'b1, 8'hD1, 1'b1);
        set_lane(0, 1'b1, 8'hE0, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_cnt++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 || tx_src !== 2'd0)
            $display("FAIL rst_mid_async got v=%0b busy=%0b rdy=%b src=%0d exp v=0 busy=0 rdy=0000 src=0",
                     tx_valid, busy, req_ready, tx_src);
        else pass_cnt++;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_held got busy=%0b exp=0", busy); else pass_cnt++;
        @(negedge clock);
        #1;
        chk_cnt++;
        if (busy !== 1'b1 || tx_src !== 2'd0 || tx_data !== 8'hE0)
            $display("FAIL rst_mid_rearb got busy=%0b src=%0d d=%h exp busy=1 src=0 d=e0", busy, tx_src, tx_data);
        else pass_cnt++;
        @(negedge clock);
        clear_inputs();
    endtask

    // Lanes are preloaded with whole packets and stay valid until drained, so the
    // expected byte stream is plain round-robin over non-empty packet queues.
    task automatic test_random();
        logic [8:0] lane_q [NR][$];
        logic [8:0] mq [NR][$];
        logic [9:0] exp_q [$];
        logic [8:0] e;
        logic [3:0] exp_rr;
        int len, last, cyc;
        bit any;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            for (int p = 0, np = $urandom_range(1, 3); p < np; p++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) lane_q[i].push_back({b == len - 1, 8'($urandom)});
            end
            mq[i] = lane_q[i];
        end
        last = NR - 1;
        any = 1;
        while (any) begin
            any = 0;
            for (int off = 1; off <= NR && !any; off++) begin
                int i = (last + off) % NR;
                if (mq[i].size() > 0) begin
                    any = 1;
                    do begin
                        e = mq[i].pop_front();
                        exp_q.push_back({2'(i), e[7:0]});
                    end while (!e[8]);
                    last = i;
                end
            end
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            @(negedge clock);
            cyc++;
            for (int i = 0; i < NR; i++) begin
                if (lane_q[i].size() > 0) set_lane(i, 1'b1, lane_q[i][0][7:0], lane_q[i][0][8]);
                else set_lane(i, 1'b0, 8'h00, 1'b0);
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rr = '0;
            if (busy) exp_rr[tx_src] = tx_ready;
            if (req_ready !== exp_rr) begin
                chk_cnt++;
                $display("FAIL rand_ready cyc%0d got=%b exp=%b", cyc, req_ready, exp_rr);
            end
            if (tx_valid && tx_ready) begin
                chk_cnt++;
                if ({tx_src, tx_data} !== exp_q[0])
                    $display("FAIL rand_xfer cyc%0d got src=%0d d=%h exp src=%0d d=%h",
                             cyc, tx_src, tx_data, exp_q[0][9:8], exp_q[0][7:0]);
                else pass_cnt++;
                void'(exp_q.pop_front());
                if (lane_q[tx_src].size() > 0) void'(lane_q[tx_src].pop_front());
            end
        end
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL rand_drain got remaining=%0d exp remaining=0", exp_q.size());
        else pass_cnt++;
        @(negedge clock);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_timeout();
        test_boundary();
        test_reset_mid();
        for (int r = 0; r < 5; r++) test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
